// File: rtl/restoring_div_pkg.sv
// Shared types and helpers for the multicycle restoring divider.
package restoring_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter must hold the value n itself, hence n + 1 codes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module restoring_div_step #(
  parameter int unsigned N = 5
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] r_sh;
  logic [N:0] trial;

  // R < D holds between iterations, so its MSB is always zero on entry.
  logic unused_r_msb;
  assign unused_r_msb = r_i[N];

  always_comb begin
    r_sh  = {r_i[N-1:0], q_i[N-1]};
    trial = r_sh - {1'b0, d_i};
    q_o   = {q_i[N-2:0], ~trial[N]};
    r_o   = trial[N] ? r_sh : trial;
  end

endmodule

// File: rtl/restoring_div.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module restoring_div
  import restoring_div_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] CntLoad = CntW'(N);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  state_e         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;

  logic [N:0]   step_r;
  logic [N-1:0] step_q;

  restoring_div_step #(
    .N(N)
  ) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(d_q),
    .r_o(step_r),
    .q_o(step_q)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          r_d   = '0;
          q_d   = dividend;
          d_d   = divisor;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            // Zero divisor short-circuits straight to a result.
            state_d = StDone;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
          end else begin
            state_d = StRun;
            cnt_d   = CntLoad;
            busy_d  = 1'b1;
          end
        end
      end
      StRun: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CntLast;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = step_q;
          rem_d   = step_r[N-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_restoring_div.sv
// Directed and exhaustive checks of restoring_div at N=5.
module tb_restoring_div;

  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_errors;

  restoring_div #(
    .N(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request; edges = clock edges after the sampling edge until done is seen.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int edges,
                        output int busy_cycles, output logic [N-1:0] q,
                        output logic [N-1:0] r, output logic z);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++;
    if (div_by_zero !== 1'b0) begin
      n_errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero);
    end
    n_checks++;
    if (quotient !== 5'd0) begin n_errors++; $display("FAIL reset_quot got=%0d exp=0", quotient); end
    n_checks++;
    if (remainder !== 5'd0) begin
      n_errors++; $display("FAIL reset_rem got=%0d exp=0", remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int edges, bc;
    logic [N-1:0] q, r;
    logic z;
    run_op(5'd23, 5'd4, edges, bc, q, r, z);
    n_checks++;
    if (edges != 5) begin n_errors++; $display("FAIL basic_latency got=%0d exp=5", edges); end
    n_checks++;
    if (bc != 5) begin n_errors++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
    n_checks++;
    if (q !== 5'd5) begin n_errors++; $display("FAIL basic_quot got=%0d exp=5", q); end
    n_checks++;
    if (r !== 5'd3) begin n_errors++; $display("FAIL basic_rem got=%0d exp=3", r); end
    n_checks++;
    if (z !== 1'b0) begin n_errors++; $display("FAIL basic_dbz got=%b exp=0", z); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    n_checks++;
    if (quotient !== 5'd5 || remainder !== 5'd3) begin
      n_errors++; $display("FAIL basic_hold got=%0d/%0d exp=5/3", quotient, remainder);
    end
  endtask

  task automatic test_edges();
    logic [N-1:0] va [4] = '{5'd31, 5'd0, 5'd7, 5'd13};
    logic [N-1:0] vb [4] = '{5'd1, 5'd7, 5'd9, 5'd0};
    logic [N-1:0] eq [4] = '{5'd31, 5'd0, 5'd0, 5'd31};
    logic [N-1:0] er [4] = '{5'd0, 5'd0, 5'd7, 5'd13};
    logic         ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int           el [4] = '{5, 5, 5, 0};
    int edges, bc;
    logic [N-1:0] q, r;
    logic z;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], edges, bc, q, r, z);
      n_checks++;
      if (edges != el[i]) begin
        n_errors++; $display("FAIL edge_latency[%0d] got=%0d exp=%0d", i, edges, el[i]);
      end
      n_checks++;
      if (q !== eq[i]) begin
        n_errors++; $display("FAIL edge_quot[%0d] got=%0d exp=%0d", i, q, eq[i]);
      end
      n_checks++;
      if (r !== er[i]) begin
        n_errors++; $display("FAIL edge_rem[%0d] got=%0d exp=%0d", i, r, er[i]);
      end
      n_checks++;
      if (z !== ez[i]) begin
        n_errors++; $display("FAIL edge_dbz[%0d] got=%b exp=%b", i, z, ez[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int ndone, lat;
    logic [N-1:0] q, r;
    logic z;
    ndone = 0; lat = -1; q = '0; r = '0; z = 1'b1;
    @(negedge clk);
    start = 1'b1; dividend = 5'd20; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (j == 2) begin start = 1'b1; dividend = 5'd9; divisor = 5'd2; end
      if (j == 3) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = j;
        q = quotient; r = remainder; z = div_by_zero;
      end
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 1) begin n_errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    n_checks++;
    if (lat != 5) begin n_errors++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    n_checks++;
    if (q !== 5'd6) begin n_errors++; $display("FAIL ignore_quot got=%0d exp=6", q); end
    n_checks++;
    if (r !== 5'd2) begin n_errors++; $display("FAIL ignore_rem got=%0d exp=2", r); end
    n_checks++;
    if (z !== 1'b0) begin n_errors++; $display("FAIL ignore_dbz_cleared got=%b exp=0", z); end
  endtask

  task automatic test_back_to_back();
    int j, k;
    logic stable;
    @(negedge clk);
    start = 1'b1; dividend = 5'd23; divisor = 5'd4;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (done !== 1'b1 && j < 20) begin
      @(negedge clk);
      j++;
    end
    n_checks++;
    if (j != 5 || quotient !== 5'd5 || remainder !== 5'd3) begin
      n_errors++;
      $display("FAIL b2b_first got=lat%0d %0d/%0d exp=lat5 5/3", j, quotient, remainder);
    end
    start = 1'b1; dividend = 5'd17; divisor = 5'd5;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    k = 0;
    stable = 1'b1;
    while (done !== 1'b1 && k < 20) begin
      if (quotient !== 5'd5 || remainder !== 5'd3) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (stable !== 1'b1) begin n_errors++; $display("FAIL b2b_hold got=changed exp=5/3 held"); end
    n_checks++;
    if (k != 5) begin n_errors++; $display("FAIL b2b_latency got=%0d exp=5", k); end
    n_checks++;
    if (quotient !== 5'd3 || remainder !== 5'd2) begin
      n_errors++; $display("FAIL b2b_second got=%0d/%0d exp=3/2", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, edges, bc;
    logic [N-1:0] q, r;
    logic z;
    @(negedge clk);
    start = 1'b1; dividend = 5'd23; divisor = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_errors++; $display("FAIL midrst_flags got=%b%b exp=00", done, div_by_zero);
    end
    n_checks++;
    if (quotient !== 5'd0 || remainder !== 5'd0) begin
      n_errors++; $display("FAIL midrst_results got=%0d/%0d exp=0/0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 0) begin n_errors++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    run_op(5'd29, 5'd6, edges, bc, q, r, z);
    n_checks++;
    if (edges != 5 || q !== 5'd4 || r !== 5'd5 || z !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_after got=lat%0d %0d/%0d z%b exp=lat5 4/5 z0", edges, q, r, z);
    end
  endtask

  task automatic test_sweep();
    int edges, bc, el;
    logic [N-1:0] q, r, eq, er;
    logic z, ez;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        run_op(N'(a), N'(b), edges, bc, q, r, z);
        if (b == 0) begin
          eq = '1; er = N'(a); ez = 1'b1; el = 0;
        end else begin
          eq = N'(a / b); er = N'(a % b); ez = 1'b0; el = 5;
        end
        n_checks++;
        if (q !== eq || r !== er || z !== ez || edges != el) begin
          n_errors++;
          $display("FAIL sweep %0d/%0d got=%0d r%0d z%b lat%0d exp=%0d r%0d z%b lat%0d",
                   a, b, q, r, z, edges, eq, er, ez, el);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_edges();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
